// File: rtl/nibble_serial_adder_pkg.sv
// rtl/nibble_serial_adder_pkg.sv - shared types and constants for the nibble-serial adder
//
// Contents:
//   NIBBLE_W   width of one add step (bits)
//   state_t    control FSM states: IDLE (accepting), RUN (adding), DONE (presenting)
//   nibbles_of helper returning the number of nibble steps for a given width
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nibbles_of(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/Adder4bit.sv
// rtl/Adder4bit.sv - combinational ripple slice adding two WIDTH-bit words plus carry-in
//
// Ports:
//   A, B   input  [WIDTH-1:0]  addends
//   Cin    input               carry-in
//   Sum    output [WIDTH-1:0]  A+B+Cin modulo 2^WIDTH
//   Cout   output              carry out of bit WIDTH-1
module Adder4bit
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = NIBBLE_W
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    logic [WIDTH:0] total;

    // One extra bit on every operand so the carry lands in total[WIDTH].
    assign total = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
    assign Sum   = total[WIDTH-1:0];
    assign Cout  = total[WIDTH];

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit adder computed one nibble per clock through a shared 4-bit slice
//
// Ports:
//   clk        input               single clock, rising edge
//   rst_n      input               asynchronous active-low reset
//   in_valid   input               operand set present
//   in_ready   output              high only in IDLE
//   A, B       input  [WIDTH-1:0]  addends, captured on accept
//   Cin        input               carry-in, captured on accept
//   out_valid  output              high only in DONE
//   out_ready  input               consumer takes the result
//   Sum        output [WIDTH-1:0]  A+B+Cin modulo 2^WIDTH
//   Cout       output              carry out of bit WIDTH-1
//
// Timing: accept on edge k, nibbles processed on edges k+1..k+NIBBLES,
// out_valid high after edge k+NIBBLES, back to IDLE on the handshake edge.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int NIBBLES = nibbles_of(WIDTH);
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int SH_LOG  = $clog2(NIBBLE_W);
    localparam int SH_W    = IDX_W + SH_LOG;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0]    a_reg;
    logic [WIDTH-1:0]    b_reg;
    logic [WIDTH-1:0]    sum_reg;
    logic                carry_reg;
    logic                cout_reg;
    logic [IDX_W-1:0]    idx;

    logic [SH_W-1:0]     shamt;
    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_cout;
    logic                last_step;

    // Bit offset of the current nibble: idx * NIBBLE_W.
    assign shamt     = {idx, {SH_LOG{1'b0}}};
    assign a_nib     = a_reg[shamt +: NIBBLE_W];
    assign b_nib     = b_reg[shamt +: NIBBLE_W];
    assign last_step = (idx == LAST_IDX);

    Adder4bit #(
        .WIDTH (NIBBLE_W)
    ) u_slice (
        .A    (a_nib),
        .B    (b_nib),
        .Cin  (carry_reg),
        .Sum  (nib_sum),
        .Cout (nib_cout)
    );

    // Control FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Control FSM: next state. The DONE->IDLE transition deliberately does
    // not look at in_valid, so a result handshake and a new accept never
    // share an edge.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Handshake outputs come straight from the state register, so there is
    // no combinational path from in_valid or out_ready to them.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Datapath: operand capture, per-nibble accumulation, final carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= A;
                        b_reg     <= B;
                        carry_reg <= Cin;
                        sum_reg   <= '0;
                        cout_reg  <= 1'b0;
                        idx       <= '0;
                    end
                end
                RUN: begin
                    sum_reg[shamt +: NIBBLE_W] <= nib_sum;
                    carry_reg                  <= nib_cout;
                    if (last_step) begin
                        cout_reg <= nib_cout;
                        // Park idx at 0 so it never passes NIBBLES-1.
                        idx      <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    // DONE holds everything until the handshake.
                end
            endcase
        end
    end

    assign Sum  = sum_reg;
    assign Cout = cout_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - scoreboard bench for nibble_serial_adder at WIDTH=16
module tb_nibble_serial_adder;

    localparam int W = 16;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] A         = '0;
    logic [W-1:0] B         = '0;
    logic         Cin       = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] Sum;
    logic         Cout;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    // Expected {Cout, Sum} values, pushed on accept and popped on result.
    logic [W:0] sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nibble_serial_adder #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Cout      (Cout)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Called at a negedge. Presents the operands until accepted, returns the
    // accept edge number, then scribbles the inputs to prove they were captured.
    task automatic drive_accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                input bit push, output int acc, output bit ok);
        A        = a;
        B        = b;
        Cin      = cin;
        in_valid = 1'b1;
        ok       = 1'b0;
        acc      = -1;
        for (int i = 0; i < 40; i++) begin
            if (in_ready === 1'b1) begin
                acc = cyc + 1;
                ok  = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        A        = W'($urandom);
        B        = W'($urandom);
        Cin      = 1'($urandom);
        if (ok && push) sb.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
    endtask

    // Called at a negedge. Returns the edge number after which out_valid was seen.
    task automatic wait_result(output int rv, output bit ok);
        ok = 1'b0;
        rv = -1;
        for (int i = 0; i < 40; i++) begin
            if (out_valid === 1'b1) begin
                rv = cyc;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int         acc, rv, rel;
        bit         ok;
        logic [W:0] exp;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, Cout, Sum} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b Cout=%b Sum=%h, required 1 0 0 0000",
                     in_ready, out_valid, Cout, Sum);
        end
        rst_n = 1'b1;
        rel   = cyc;
        drive_accept(16'h1234, 16'h4321, 1'b0, 1'b1, acc, ok);
        checks++;
        if (!ok || acc !== rel + 1) begin
            errors++;
            $display("FAIL first_accept: accepted=%0b at edge %0d, required edge %0d", ok, acc, rel + 1);
        end
        wait_result(rv, ok);
        checks++;
        if (!ok || rv - acc !== 4) begin
            errors++;
            $display("FAIL basic_latency: seen=%0b latency %0d, required 4", ok, rv - acc);
        end
        exp = (sb.size() != 0) ? sb.pop_front() : 17'h1ffff;
        checks++;
        if ({Cout, Sum} !== exp || exp !== 17'h05555) begin
            errors++;
            $display("FAIL basic_sum: got Cout=%b Sum=%h, required %h", Cout, Sum, exp);
        end
        take_result();
    endtask

    task automatic test_carry();
        logic [W-1:0] ta[2] = '{16'hFFFF, 16'hFFFF};
        logic [W-1:0] tb[2] = '{16'h0001, 16'h0000};
        logic         tc[2] = '{1'b0, 1'b1};
        int           acc, rv;
        bit           ok;
        logic [W:0]   exp;
        for (int n = 0; n < 2; n++) begin
            drive_accept(ta[n], tb[n], tc[n], 1'b1, acc, ok);
            wait_result(rv, ok);
            checks++;
            if (!ok || rv - acc !== 4) begin
                errors++;
                $display("FAIL carry_latency[%0d]: seen=%0b latency %0d, required 4", n, ok, rv - acc);
            end
            exp = (sb.size() != 0) ? sb.pop_front() : 17'h0;
            checks++;
            if ({Cout, Sum} !== exp || exp !== 17'h10000) begin
                errors++;
                $display("FAIL carry_ripple[%0d]: got Cout=%b Sum=%h, required %h", n, Cout, Sum, exp);
            end
            take_result();
        end
    endtask

    task automatic test_stall();
        int         acc, rv, late;
        bit         ok;
        logic [W:0] exp;
        drive_accept(16'h0F0F, 16'h0101, 1'b1, 1'b1, acc, ok);
        wait_result(rv, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stall_result: no out_valid, required one");
        end
        exp      = (sb.size() != 0) ? sb.pop_front() : 17'h1ffff;
        A        = 16'h0001;
        B        = 16'h0000;
        Cin      = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({out_valid, in_ready, Cout, Sum} !== {1'b1, 1'b0, exp}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: out_valid=%b in_ready=%b Cout=%b Sum=%h, required 1 0 %h",
                         i, out_valid, in_ready, Cout, Sum, exp);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL stall_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        late = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) late++;
        end
        checks++;
        if (late !== 0) begin
            errors++;
            $display("FAIL stall_no_accept: %0d busy cycles after release, required 0", late);
        end
    endtask

    task automatic test_reset_mid();
        int         acc, rv, busy;
        bit         ok;
        logic [W:0] exp;
        drive_accept(16'hAAAA, 16'h5555, 1'b0, 1'b0, acc, ok);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, Cout, Sum} !== {1'b0, 1'b1, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL reset_mid: out_valid=%b in_ready=%b Cout=%b Sum=%h, required 0 1 0 0000",
                     out_valid, in_ready, Cout, Sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        busy  = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid !== 1'b0) busy++;
        end
        checks++;
        if (busy !== 0) begin
            errors++;
            $display("FAIL reset_discard: out_valid seen %0d times, required 0", busy);
        end
        drive_accept(16'h00FF, 16'h0001, 1'b0, 1'b1, acc, ok);
        wait_result(rv, ok);
        exp = (sb.size() != 0) ? sb.pop_front() : 17'h0;
        checks++;
        if (!ok || {Cout, Sum} !== exp || exp !== 17'h00100) begin
            errors++;
            $display("FAIL reset_next_op: seen=%0b Cout=%b Sum=%h, required %h", ok, Cout, Sum, exp);
        end
        take_result();
    endtask

    task automatic test_back_to_back();
        int           acc, rv, prev;
        bit           ok, ok_r;
        logic [W-1:0] a, b;
        logic         c;
        logic [W:0]   exp;
        prev      = -1;
        out_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom);
            drive_accept(a, b, c, 1'b1, acc, ok);
            checks++;
            if (!ok || (prev >= 0 && acc - prev !== 6)) begin
                errors++;
                $display("FAIL b2b_interval[%0d]: accepted=%0b interval %0d, required 6", n, ok, acc - prev);
            end
            prev = acc;
            wait_result(rv, ok_r);
            exp = (sb.size() != 0) ? sb.pop_front() : 17'h0;
            checks++;
            if (!ok_r || {Cout, Sum} !== exp) begin
                errors++;
                $display("FAIL b2b_sum[%0d]: seen=%0b got Cout=%b Sum=%h, required %h for %h+%h+%b",
                         n, ok_r, Cout, Sum, exp, a, b, c);
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_empty: %0d entries left, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_carry();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width; legal values are multiples of 4, minimum 8.
REQ-002 SHALL derive constant NIBBLES = WIDTH/4, the number of nibble steps per operation.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operand set present.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand set.
REQ-007 SHALL have port A  input  WIDTH  addend A.
REQ-008 SHALL have port B  input  WIDTH  addend B.
REQ-009 SHALL have port Cin  input  1  carry-in.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port Sum  output  WIDTH  result sum, A+B+Cin modulo 2^WIDTH.
REQ-013 SHALL have port Cout  output  1  carry out of bit WIDTH-1.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 On in_valid&&in_ready at edge k: capture A, B, Cin into internal registers, clear nibble index to 0, go to RUN.
REQ-017 In RUN, each edge SHALL add nibble[idx] of A and B plus the carry register, write the 4-bit result into Sum nibble[idx], update the carry register, and increment idx.
REQ-018 On the edge processing idx = NIBBLES-1, the FSM SHALL go to DONE and load Cout from the final carry; latency from accept edge k to out_valid high is exactly NIBBLES edges (k+NIBBLES).
REQ-019 In DONE, Sum and Cout SHALL hold stable until out_valid&&out_ready; on that edge the FSM SHALL go to IDLE (no same-cycle re-accept).
REQ-020 in_valid while in RUN or DONE SHALL be ignored; A/B/Cin changes after capture SHALL not affect the result.
REQ-021 out_ready while not in DONE SHALL have no effect.
REQ-022 Throughput SHALL be one operation per NIBBLES+2 cycles with out_ready held high.
REQ-023 The nibble index SHALL be ceil(log2(NIBBLES)) bits wide and SHALL never exceed NIBBLES-1.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, idx 0, carry 0, Sum 0, Cout 0, out_valid 0, in_ready 1.
REQ-025 Reset asserted mid-RUN or in DONE SHALL discard the operation with no partial result presented.
REQ-026 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-027 A shared package SHALL hold the FSM state enum and the nibble width constant (4).
REQ-028 Exactly one sub-module SHALL be instantiated: the team's existing Adder4bit slice (WIDTH=4), reused every RUN cycle for the nibble add.
REQ-029 Datapath registers SHALL be the operand registers, Sum register, carry register and idx; no combinational path from in_valid to in_ready, nor from out_ready to out_valid.

Verification (WIDTH=16)
REQ-030 A=0x1234, B=0x4321, Cin=0 accepted at edge k -> out_valid at k+4, Sum=0x5555, Cout=0.
REQ-031 A=0xFFFF, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1 (carry rippled through all 4 nibbles); A=0xFFFF, B=0x0000, Cin=1 -> Sum=0x0000, Cout=1.
REQ-032 out_ready held low 3 cycles in DONE -> Sum/Cout/out_valid stable, in_ready 0; a new in_valid with A=0x0001 during the stall is not accepted.
REQ-033 rst_n pulsed low at k+2 of an op -> out_valid 0, Sum 0, in_ready 1 immediately; the next op A=0x00FF, B=0x0001, Cin=0 -> Sum=0x0100, Cout=0.
REQ-034 Back-to-back random ops with out_ready=1 -> every result matches A+B+Cin, accept interval exactly 6 cycles.
